// File: rtl/mem_fill_verify_pkg.sv
// mem_fill_verify_pkg
//   Shared definitions for the memory fill/verify controller: FSM state
//   encoding, pattern mode encodings, the LFSR polynomial with its step
//   function, and default widths.
package mem_fill_verify_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;
  localparam int RD_LAT_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_INCR = 2'b00,
    MODE_WALK = 2'b01,
    MODE_LFSR = 2'b10,
    MODE_INV  = 2'b11
  } mode_t;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  // The x^0 term of the polynomial is the feedback bit shifted out, not a
  // tap, so it is dropped from the XOR mask: seed 1 steps to 0x80200002.
  localparam logic [31:0] LFSR_TAPS = {LFSR_POLY[31:1], 1'b0};

  // Right-shifting Galois LFSR, one step.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/mem_fill_verify_if.sv
// mem_fill_verify_if
//   Single-port synchronous memory bus between the fill/verify controller
//   (master) and the memory under test (slave).
//   cs      chip select
//   rw_     1 = read, 0 = write
//   adder   word address
//   datain  write data toward memory
//   dataout read data from memory, valid RD_LAT cycles after a read cycle
interface mem_fill_verify_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              cs;
  logic              rw_;
  logic [ADDR_W-1:0] adder;
  logic [DATA_W-1:0] datain;
  logic [DATA_W-1:0] dataout;

  modport master (output cs, rw_, adder, datain, input dataout);
  modport slave  (input cs, rw_, adder, datain, output dataout);
endinterface

// File: rtl/mem_fill_verify_pattern_gen.sv
// mem_pattern_gen
//   Produces the test word for the current address. Modes 00/01/11 are pure
//   functions of seed and address; mode 10 uses a 32-bit LFSR register that
//   is reloaded at the start of each sweep and stepped once per address.
//   clk, reset  clock and synchronous active-high reset
//   mode, seed  pattern selection and seed
//   addr        current sweep address
//   step        advance the LFSR to the next address
//   reload      load the LFSR from seed (1 if seed is 0); wins over step
//   word        pattern word for addr
module mem_pattern_gen
  import mem_fill_verify_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  mode_t             mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [ADDR_W-1:0] addr,
  input  logic              step,
  input  logic              reload,
  output logic [DATA_W-1:0] word
);

  logic [31:0] lfsr_q;
  logic [31:0] seed32;
  logic [31:0] lfsr_load;
  int          walk_sh;

  assign seed32    = 32'(seed);
  assign lfsr_load = (seed32 == 32'd0) ? 32'd1 : seed32;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 32'd0;
    end else if (reload) begin
      lfsr_q <= lfsr_load;
    end else if (step) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  always_comb begin
    word    = '0;
    walk_sh = int'(addr) % DATA_W;
    case (mode)
      MODE_INCR: word = seed + DATA_W'(addr);
      MODE_WALK: word = {{(DATA_W-1){1'b0}}, 1'b1} << walk_sh;
      MODE_LFSR: word = DATA_W'(lfsr_q);
      MODE_INV:  word = ~(seed + DATA_W'(addr));
      default:   word = '0;
    endcase
  end

endmodule

// File: rtl/mem_fill_verify.sv
// mem_fill_verify
//   Fills every word of a memory with a selectable pattern, reads it all
//   back, and compares each returned word against the same pattern delayed
//   by the memory read latency.
//   clk, reset      clock and synchronous active-high reset
//   start           run request, honoured only in IDLE
//   mode, seed      pattern select and seed, latched when a run starts
//   mem             memory bus (master side)
//   busy            run in progress (WRITE, READ, DRAIN)
//   done            one-cycle completion pulse
//   err             at least one mismatch in the last run
//   err_count       mismatching words, saturating at 2**ADDR_W
//   first_err_addr  address of the first mismatch, 0 if none
//
// state  | meaning
// IDLE   | waiting for start; results of the last run held
// WRITE  | writing pattern(addr) for addr 0..max
// READ   | issuing reads for addr 0..max
// DRAIN  | RD_LAT cycles for the last reads to return and be compared
// DONE   | one-cycle done pulse, then IDLE
module mem_fill_verify
  import mem_fill_verify_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [DATA_W-1:0]   seed,
  mem_fill_verify_if.master   mem,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W:0]     err_count,
  output logic [ADDR_W-1:0]   first_err_addr
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W:0] ERR_SAT = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              last_addr;
  mode_t             mode_q;
  logic [DATA_W-1:0] seed_q;
  logic [LAT_W-1:0]  drain_q;
  logic              accept;

  logic [DATA_W-1:0] gen_seed;
  logic              gen_step;
  logic              gen_reload;
  logic [DATA_W-1:0] gen_word;

  logic [RD_LAT-1:0] vld_pipe;
  logic [DATA_W-1:0] exp_pipe [RD_LAT];
  logic [ADDR_W-1:0] adr_pipe [RD_LAT];
  logic              mismatch;

  logic              err_q;
  logic [ADDR_W:0]   err_count_q;
  logic [ADDR_W-1:0] first_err_q;

  assign last_addr = (addr_q == {ADDR_W{1'b1}});
  assign accept    = (state_q == ST_IDLE) && start;

  // The LFSR reloads on the start edge, before seed_q has captured the new
  // seed, so the live seed input is used while idle.
  assign gen_seed   = (state_q == ST_IDLE) ? seed : seed_q;
  assign gen_reload = accept || ((state_q == ST_WRITE) && last_addr);
  assign gen_step   = (state_q == ST_WRITE) || (state_q == ST_READ);

  mem_pattern_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pattern_gen (
    .clk    (clk),
    .reset  (reset),
    .mode   (mode_q),
    .seed   (gen_seed),
    .addr   (addr_q),
    .step   (gen_step),
    .reload (gen_reload),
    .word   (gen_word)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_WRITE;
      ST_WRITE: if (last_addr) state_d = ST_READ;
      ST_READ:  if (last_addr) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    mem.cs     = 1'b0;
    mem.rw_    = 1'b1;
    mem.adder  = '0;
    mem.datain = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_WRITE: begin
        mem.cs     = 1'b1;
        mem.rw_    = 1'b0;
        mem.adder  = addr_q;
        mem.datain = gen_word;
        busy       = 1'b1;
      end
      ST_READ: begin
        mem.cs    = 1'b1;
        mem.adder = addr_q;
        busy      = 1'b1;
      end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Sweep address, run configuration and drain timer
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      mode_q  <= MODE_INCR;
      seed_q  <= '0;
      drain_q <= '0;
    end else begin
      if ((state_q == ST_WRITE) || (state_q == ST_READ)) begin
        addr_q <= addr_q + 1'b1;
      end else begin
        addr_q <= '0;
      end
      if (accept) begin
        mode_q <= mode_t'(mode);
        seed_q <= seed;
      end
      if ((state_q == ST_READ) && last_addr) begin
        drain_q <= LAT_W'(RD_LAT - 1);
      end else if ((state_q == ST_DRAIN) && (drain_q != '0)) begin
        drain_q <= drain_q - 1'b1;
      end
    end
  end

  // Expected-data pipeline aligned with the memory read latency
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        exp_pipe[i] <= '0;
        adr_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= (state_q == ST_READ);
      exp_pipe[0] <= gen_word;
      adr_pipe[0] <= addr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        exp_pipe[i] <= exp_pipe[i-1];
        adr_pipe[i] <= adr_pipe[i-1];
      end
    end
  end

  assign mismatch = vld_pipe[RD_LAT-1] && (mem.dataout != exp_pipe[RD_LAT-1]);

  // Result registers: cleared on start, updated on each mismatch
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q       <= 1'b0;
      err_count_q <= '0;
      first_err_q <= '0;
    end else if (accept) begin
      err_q       <= 1'b0;
      err_count_q <= '0;
      first_err_q <= '0;
    end else if (mismatch) begin
      err_q <= 1'b1;
      if (err_count_q != ERR_SAT) begin
        err_count_q <= err_count_q + 1'b1;
      end
      if (!err_q) begin
        first_err_q <= adr_pipe[RD_LAT-1];
      end
    end
  end

  assign err            = err_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_q;

endmodule
